// File: rtl/phase_diff_avg_pkg.sv
// phase_pkg: shared types and modular phase arithmetic for phase_diff_avg
package phase_pkg;
  localparam int PHASE_W = 16;
  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;
  typedef logic signed [PHASE_W-1:0] phase_t;
  function automatic phase_t wrap_sub(phase_t a, phase_t b);
    return a - b;
  endfunction
endpackage

// File: rtl/phase_diff_avg_if.sv
// phase_diff_avg_if: peak-record sink stream, averaged-phase source stream and overrun flag
interface phase_diff_avg_if #(parameter int CHANNELS = 4) ();
  import phase_pkg::*;
  localparam int CW = $clog2(CHANNELS);
  logic sink_valid, sink_ready, sink_sop, sink_eop;
  logic [CW-1:0] sink_chan;
  logic signed [31:0] sink_freq, sink_mag;
  phase_t sink_phase;
  logic source_ready, source_valid, source_sop, source_eop, source_error;
  logic [CW-1:0] source_chan;
  logic signed [31:0] source_freq;
  phase_t source_phase;
  logic overrun;
  modport slave(
    input sink_valid, sink_sop, sink_eop, sink_chan, sink_freq, sink_mag, sink_phase, source_ready,
    output sink_ready, source_valid, source_sop, source_eop, source_chan, source_freq, source_phase,
    source_error, overrun
  );
  modport master(
    output sink_valid, sink_sop, sink_eop, sink_chan, sink_freq, sink_mag, sink_phase, source_ready,
    input sink_ready, source_valid, source_sop, source_eop, source_chan, source_freq, source_phase,
    source_error, overrun
  );
endinterface

// File: rtl/phase_acc_bank.sv
// phase_acc_bank: per-channel run-0 reference phase and wrap-safe deviation accumulator
module phase_acc_bank import phase_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int AW = 18
) (
  input  logic clk,
  input  logic we,
  input  logic run0,
  input  logic [$clog2(CHANNELS)-1:0] wch,
  input  logic [$clog2(CHANNELS)-1:0] rch,
  input  phase_t d,
  output phase_t rd_ref,
  output logic signed [AW-1:0] rd_acc
);
  phase_t ref_q [CHANNELS];
  logic signed [AW-1:0] acc_q [CHANNELS];
  always_ff @(posedge clk)
    if (we) begin
      ref_q[wch] <= run0 ? d : ref_q[wch];
      acc_q[wch] <= run0 ? '0 : acc_q[wch] + AW'(wrap_sub(d, ref_q[wch]));
    end
  assign rd_ref = ref_q[rch];
  assign rd_acc = acc_q[rch];
endmodule

// File: rtl/phase_diff_avg.sv
// phase_diff_avg: averages per-channel phase relative to channel 0 over 2^RUNS_LOG2 runs
module phase_diff_avg import phase_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int RUNS_LOG2 = 2,
  parameter int PHASE_WIDTH = PHASE_W,
  parameter int MAG_MIN = 0
) (
  input logic clk,
  input logic reset,
  phase_diff_avg_if.slave bus
);
  localparam int CW = $clog2(CHANNELS);
  localparam int AW = PHASE_WIDTH + RUNS_LOG2;
  localparam int HALF = (1 << RUNS_LOG2) >> 1;
  localparam logic [RUNS_LOG2:0] LAST_RUN = (RUNS_LOG2 + 1)'((1 << RUNS_LOG2) - 1);
  localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);
  state_t state, next;
  logic [RUNS_LOG2:0] run;
  logic [CW-1:0] exp_ch, e_ch;
  phase_t ph0, d, rd_ref;
  logic signed [AW-1:0] rd_acc, rnd;
  logic signed [31:0] freq_ref;
  logic err, take, frame_ok, start, good, mag_low, load, done;
  assign bus.sink_ready = state != EMIT;
  assign take = bus.sink_valid && bus.sink_ready;
  assign frame_ok = bus.sink_chan == exp_ch && bus.sink_sop == (exp_ch == '0) && bus.sink_eop == (exp_ch == LAST_CH);
  // a misframed sop on ch 0 restarts a batch instead of just dropping it
  assign start = take && bus.sink_sop && bus.sink_chan == '0 && (state == IDLE || !frame_ok);
  assign good = take && state == COLLECT && frame_ok && !start;
  assign mag_low = bus.sink_mag < MAG_MIN;
  assign d = (start || exp_ch == '0) ? '0 : wrap_sub(bus.sink_phase, ph0);
  assign load = state == EMIT && (!bus.source_valid || (bus.source_ready && !bus.source_eop));
  assign done = state == EMIT && bus.source_valid && bus.source_ready && bus.source_eop;
  assign rnd = rd_acc + AW'(HALF);
  phase_acc_bank #(.CHANNELS(CHANNELS), .AW(AW)) bank (
    .clk(clk), .we(start || good), .run0(start || run == '0), .wch(bus.sink_chan), .rch(e_ch),
    .d(d), .rd_ref(rd_ref), .rd_acc(rd_acc)
  );
  always_comb begin
    next = state;
    if (start) next = COLLECT;
    else if (take && state == COLLECT && !frame_ok) next = IDLE;
    else if (good && bus.sink_eop && run == LAST_RUN) next = EMIT;
    else if (done) next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      run <= '0;
      exp_ch <= '0;
      e_ch <= '0;
      ph0 <= '0;
      freq_ref <= '0;
      err <= 1'b0;
      bus.overrun <= 1'b0;
      bus.source_valid <= 1'b0;
      bus.source_sop <= 1'b0;
      bus.source_eop <= 1'b0;
      bus.source_chan <= '0;
      bus.source_freq <= '0;
      bus.source_phase <= '0;
      bus.source_error <= 1'b0;
    end else begin
      state <= next;
      if (bus.sink_valid && !bus.sink_ready) bus.overrun <= 1'b1;
      if (start) begin
        run <= '0;
        exp_ch <= CW'(1);
        ph0 <= bus.sink_phase;
        freq_ref <= bus.sink_freq;
        err <= mag_low;
      end else if (good) begin
        if (exp_ch == '0) ph0 <= bus.sink_phase;
        err <= err || bus.sink_freq != freq_ref || mag_low;
        exp_ch <= bus.sink_eop ? '0 : exp_ch + 1'b1;
        if (bus.sink_eop) run <= run + 1'b1;
        e_ch <= CW'(1);
      end
      if (load) begin
        bus.source_valid <= 1'b1;
        bus.source_sop <= e_ch == CW'(1);
        bus.source_eop <= e_ch == LAST_CH;
        bus.source_chan <= e_ch;
        bus.source_freq <= freq_ref;
        bus.source_phase <= rd_ref + phase_t'(rnd >>> RUNS_LOG2);
        bus.source_error <= err;
        e_ch <= e_ch + 1'b1;
      end else if (done) bus.source_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_phase_diff_avg.sv
// tb_phase_diff_avg: directed vectors with hand-computed averaged phases
module tb_phase_diff_avg;
  import phase_pkg::*;
  logic clk = 0, reset = 1;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  phase_diff_avg_if #(.CHANNELS(4)) bus ();
  phase_diff_avg #(.CHANNELS(4), .RUNS_LOG2(2), .PHASE_WIDTH(16), .MAG_MIN(0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic send(input int ch, input int ph, input int freq = 100, input int mag = 10);
    bus.sink_valid = 1;
    bus.sink_sop = ch == 0;
    bus.sink_eop = ch == 3;
    bus.sink_chan = 2'(ch);
    bus.sink_freq = freq;
    bus.sink_mag = mag;
    bus.sink_phase = phase_t'(ph);
    @(posedge clk); #1;
    bus.sink_valid = 0;
  endtask
  task automatic send_run(input int p0, p1, p2, p3, input int f2 = 100, input int m1 = 10);
    send(0, p0);
    send(1, p1, 100, m1);
    send(2, p2, f2);
    send(3, p3);
  endtask
  task automatic wait_valid();
    int k = 0;
    while (!bus.source_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
  endtask
  task automatic expect_batch(input string tag, input int e1, e2, e3, input int err);
    int e[3];
    e = '{e1, e2, e3};
    wait_valid();
    check({tag, "_valid"}, bus.source_valid, 1);
    for (int c = 1; c < 4; c++) begin
      check({tag, "_chan"}, bus.source_chan, c);
      check({tag, "_phase"}, bus.source_phase, e[c-1]);
      check({tag, "_sop"}, bus.source_sop, c == 1);
      check({tag, "_eop"}, bus.source_eop, c == 3);
      check({tag, "_err"}, bus.source_error, err);
      check({tag, "_freq"}, bus.source_freq, 100);
      check({tag, "_busy"}, bus.sink_ready, 0);
      @(posedge clk); #1;
    end
    check({tag, "_end"}, bus.source_valid, 0);
    check({tag, "_rdy"}, bus.sink_ready, 1);
  endtask
  initial begin
    bus.sink_valid = 0;
    bus.sink_sop = 0;
    bus.sink_eop = 0;
    bus.sink_chan = 0;
    bus.sink_freq = 0;
    bus.sink_mag = 0;
    bus.sink_phase = 0;
    bus.source_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.source_valid, 0);
    check("rst_ready", bus.sink_ready, 1);
    check("rst_overrun", bus.overrun, 0);
    check("rst_phase", bus.source_phase, 0);
    reset = 0;
    repeat (3) send_run(1000, 3000, 1000, -2000);
    send_run(1000, 3000, 1000, -2000);
    check("lat_t1_busy", bus.sink_ready, 0);
    check("lat_t1_valid", bus.source_valid, 0);
    @(posedge clk); #1;
    check("lat_t2_valid", bus.source_valid, 1);
    check("lat_t2_chan", bus.source_chan, 1);
    expect_batch("basic", 2000, 0, -3000, 0);
    send_run(32000, 33530, 32000, 32000);
    send_run(32000, 33540, 32000, 32000);
    send_run(32000, -32000, 32000, 32000);
    send_run(32000, 33540, 32000, 32000);
    expect_batch("wrap", 1537, 0, 0, 0);
    send_run(0, 32760, 0, 0);
    send_run(0, -32760, 0, 0);
    send_run(0, 32760, 0, 0);
    send_run(0, -32760, 0, 0);
    expect_batch("pi", -32768, 0, 0, 0);
    repeat (3) send_run(1000, 3000, 1000, -2000);
    send_run(1000, 3000, 1000, -2000, 101);
    expect_batch("freq_err", 2000, 0, -3000, 1);
    repeat (4) send_run(1000, 3000, 1000, -2000);
    expect_batch("clean", 2000, 0, -3000, 0);
    send_run(1000, 3000, 1000, -2000);
    send_run(1000, 3000, 1000, -2000, 100, -5);
    repeat (2) send_run(1000, 3000, 1000, -2000);
    expect_batch("mag_err", 2000, 0, -3000, 1);
    send(0, 0);
    send(2, 5);
    send(3, 5);
    repeat (5) @(posedge clk);
    #1;
    check("frame_nout", bus.source_valid, 0);
    check("frame_idle", bus.sink_ready, 1);
    repeat (4) send_run(0, 100, 200, 300);
    expect_batch("frame_next", 100, 200, 300, 0);
    send_run(0, 10, 20, 30);
    send(0, 7);
    send(1, 7777);
    repeat (4) send_run(500, 600, 900, 400);
    expect_batch("restart", 100, 400, -100, 0);
    bus.source_ready = 0;
    repeat (4) send_run(1000, 3000, 1000, -2000);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", bus.source_valid, 1);
      check("hold_chan", bus.source_chan, 1);
      check("hold_phase", bus.source_phase, 2000);
      if (i == 1) bus.sink_valid = 1;
      @(posedge clk); #1;
      bus.sink_valid = 0;
    end
    check("overrun_set", bus.overrun, 1);
    bus.source_ready = 1;
    expect_batch("bp", 2000, 0, -3000, 0);
    check("overrun_sticky", bus.overrun, 1);
    bus.source_ready = 0;
    repeat (4) send_run(1000, 3000, 1000, -2000);
    wait_valid();
    check("pre_rst_valid", bus.source_valid, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    check("emit_rst_valid", bus.source_valid, 0);
    check("emit_rst_overrun", bus.overrun, 0);
    check("emit_rst_ready", bus.sink_ready, 1);
    check("emit_rst_phase", bus.source_phase, 0);
    bus.source_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    check("emit_rst_quiet", bus.source_valid, 0);
    repeat (4) send_run(1000, 3000, 1000, -2000);
    expect_batch("post_rst", 2000, 0, -3000, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/phase_diff_avg.md
# phase_diff_avg

Multi-channel phase-difference averager placed after one `peak_detect` instance per antenna channel, with the peak records time-multiplexed onto a single stream. For each run it computes every channel's peak phase relative to channel 0. It averages these differences over 2^RUNS_LOG2 runs with wrap-safe arithmetic and emits one averaged record per non-reference channel. It also flags frequency disagreement and weak peaks.

## Interface
- CHANNELS, 4: antenna channels per run, ≥2; channel 0 is the phase reference.
- RUNS_LOG2, 2: log2 of runs averaged per batch; 0 gives no averaging.
- PHASE_WIDTH, 16: phase bits; full scale 2^PHASE_WIDTH = 2π, two's complement.
- MAG_MIN, 0: a record with sink_mag < MAG_MIN marks the batch bad.
- clk  in  1  main clock.
- reset  in  1  synchronous, active-high.
- sink_valid  in  1  record present.
- sink_sop / sink_eop  in  1  first (ch 0) / last (ch CHANNELS-1) record of a run.
- sink_chan  in  $clog2(CHANNELS)  channel index of the record.
- sink_freq  in  32 signed  peak bin.
- sink_mag  in  32 signed  peak magnitude.
- sink_phase  in  PHASE_WIDTH signed  peak phase.
- sink_ready  out  1  record accepted when sink_valid && sink_ready.
- source_ready  in  1  downstream accept.
- source_valid / source_sop / source_eop  out  1  output record strobes.
- source_chan  out  $clog2(CHANNELS)  channel, 1..CHANNELS-1.
- source_phase  out  PHASE_WIDTH signed  averaged phase(ch) − phase(ch 0).
- source_freq  out  32 signed  channel-0 frequency of run 0.
- source_error  out  1  batch bad: frequency mismatch or magnitude below MAG_MIN.
- overrun  out  1  sticky; set by sink_valid && !sink_ready; cleared only by reset.

## Operation
- States: IDLE, COLLECT, EMIT.
- IDLE → COLLECT on an accepted record with sink_sop and sink_chan=0. A non-sop record in IDLE is ignored.
- COLLECT:
  - Records must arrive in order 0..CHANNELS-1, sop on ch 0, eop on ch CHANNELS-1. Gaps between records are allowed.
  - Per record, d = wrap(phase − phase_ch0_of_this_run), taken modulo 2^PHASE_WIDTH.
  - Run 0: store ref[ch]=d; acc[ch]=0; store freq_ref from ch 0.
  - Run r>0: acc[ch] += wrap(d − ref[ch]). acc is PHASE_WIDTH+RUNS_LOG2 bits signed.
  - Error flag set if sink_freq ≠ freq_ref, or if sink_mag < MAG_MIN, for any record of any run.
  - Frame error: wrong sink_chan, sop on a channel other than 0, or eop missing/misplaced. The whole batch is discarded with no output, next state IDLE. If the offending record is itself a valid sop with ch 0, it starts a new batch.
  - After eop of run 2^RUNS_LOG2−1 → EMIT.
- EMIT:
  - source_phase = ref[ch] + ((acc[ch] + 2^(RUNS_LOG2−1)) >>> RUNS_LOG2), truncated to PHASE_WIDTH (wraps). The rounding term is 0 when RUNS_LOG2=0.
  - Channels 1..CHANNELS-1 are emitted in order; sop on ch 1, eop on ch CHANNELS-1. source_error is constant over the batch.
  - sink_ready=0 throughout EMIT.
- Reset values: all source_* = 0, sink_ready=1, overrun=0, state IDLE, flags cleared.

## Timing
- Records are accepted one per cycle when valid and ready; sink_ready is 1 in IDLE/COLLECT.
- Final record of the batch accepted at cycle T → source_valid=1 at T+2 with ch 1; sink_ready=0 from T+1.
- Output advances on each cycle with source_valid && source_ready. While source_ready=0, all source_* hold stable.
- eop handshake at cycle E → source_valid=0 and sink_ready=1 at E+1; state IDLE.
- Reset mid-batch or mid-EMIT: the cycle after reset, outputs are at reset values and no residual records follow.

## Structure
- Package `phase_pkg`:
  - state enum
  - `phase_t` typedef
  - `wrap_sub` function (PHASE_WIDTH modular subtract)
- Sub-module `phase_acc_bank`: ref/acc register arrays, written by channel index and read by the EMIT counter.
- Top holds the FSM, the run and channel counters, and the error flags.

## Test plan
- CHANNELS=4, RUNS_LOG2=2; each of 4 runs has phases {1000, 3000, 1000, −2000}, freq 100 → outputs ch1..3 = 2000, 0, −3000; error 0; first output at T+2.
- Wrap: ch0=32000, ch1=−32000 gives d=1536. ch1 diffs across runs of 1530, 1540, 1536, 1540 → output 1537.
- ±π boundary: diffs across runs of 32760, −32760, 32760, −32760 → output −32768, no large-error artefact.
- Run 3, ch2 freq 101 (others 100), or one mag < MAG_MIN → batch emitted, source_error=1. The next clean batch gives error 0.
- Frame error: sink_chan=2 where 1 is expected → no output, IDLE. The following correct batch produces the correct result.
- source_ready low for 3 cycles after sop → outputs held. A sink_valid during EMIT sets overrun=1. Reset during EMIT → source_valid=0 next cycle and overrun=0.
